writeback_arbiter: RTL

- Writeback stage directly upstream of the register bank: merges ALU results and memory load results into the bank's single write port (enable/select/data).
- Each source has a small queue with a valid/ready handshake. A fixed-priority arbiter with a starvation guard picks one write per cycle and drives registered write outputs.
- Also exports a pending-write mask, which hazard logic uses to stall reads of registers with queued results.

---
 rtl/writeback_pkg.sv | 13 +
 rtl/writeback_fifo.sv | 84 ++++++++
 rtl/writeback_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/writeback_pkg.sv
// Shared types and default sizing for the writeback arbiter and its source queues.
package writeback_pkg;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM
  } wb_src_t;

  localparam int unsigned DEFAULT_FIFO_DEPTH   = 2;
  localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/writeback_fifo.sv
// Per-source result queue: in-order FIFO with wrapping pointers, a separate count,
// and a per-entry valid/select view so the top can build the pending-write mask.
module writeback_fifo
  import writeback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SELECT_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  localparam int unsigned COUNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_push,
  input  logic [SELECT_WIDTH-1:0]            i_push_select,
  input  logic [DATA_WIDTH-1:0]              i_push_data,
  output logic                               o_ready,
  input  logic                               i_pop,
  output logic [SELECT_WIDTH-1:0]            o_head_select,
  output logic [DATA_WIDTH-1:0]              o_head_data,
  output logic [COUNT_WIDTH-1:0]             o_count,
  output logic [FIFO_DEPTH-1:0]              o_entry_valid,
  output logic [FIFO_DEPTH*SELECT_WIDTH-1:0] o_entry_select
);

  localparam int unsigned PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [SELECT_WIDTH-1:0] sel_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    push_en, pop_en;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // Ready depends on count only, so a same-cycle pop never admits a push.
  assign o_ready = (count_q < COUNT_WIDTH'(FIFO_DEPTH));
  assign push_en = i_push && o_ready;
  assign pop_en  = i_pop && (count_q != '0);

  always_comb begin
    rd_ptr_d = pop_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    if (push_en && !pop_en) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end else if (!push_en && pop_en) begin
      count_d = count_q - COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      sel_q[wr_ptr_q]  <= i_push_select;
      data_q[wr_ptr_q] <= i_push_data;
    end
  end

  assign o_head_select = sel_q[rd_ptr_q];
  assign o_head_data   = data_q[rd_ptr_q];
  assign o_count       = count_q;

  // Entry g is live when its distance from the read pointer is below the count.
  for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_entry
    assign o_entry_valid[g] =
        ((g + FIFO_DEPTH - 32'(rd_ptr_q)) % FIFO_DEPTH) < 32'(count_q);
    assign o_entry_select[g*SELECT_WIDTH +: SELECT_WIDTH] = sel_q[g];
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results into the register bank's single write port, with a
// MEM-first priority, an ALU starvation guard, and a pending-write mask for hazards.
module writeback_arbiter
  import writeback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_REG      = 32,
  parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  localparam int unsigned SELECT_WIDTH = $clog2(NUM_REG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_alu_valid,
  output logic                    o_alu_ready,
  input  logic [SELECT_WIDTH-1:0] i_alu_select,
  input  logic [DATA_WIDTH-1:0]   i_alu_data,
  input  logic                    i_mem_valid,
  output logic                    o_mem_ready,
  input  logic [SELECT_WIDTH-1:0] i_mem_select,
  input  logic [DATA_WIDTH-1:0]   i_mem_data,
  output logic                    o_write_enable,
  output logic [SELECT_WIDTH-1:0] o_write_select,
  output logic [DATA_WIDTH-1:0]   o_write_data,
  output logic [NUM_REG-1:0]      o_pending
);

  localparam int unsigned COUNT_WIDTH  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STARVE_WIDTH = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [SELECT_WIDTH-1:0]            alu_head_select, mem_head_select, head_select;
  logic [DATA_WIDTH-1:0]              alu_head_data, mem_head_data, head_data;
  logic [COUNT_WIDTH-1:0]             alu_count, mem_count;
  logic [FIFO_DEPTH-1:0]              alu_entry_valid, mem_entry_valid;
  logic [FIFO_DEPTH*SELECT_WIDTH-1:0] alu_entry_select, mem_entry_select;
  logic                               alu_nonempty, mem_nonempty;
  wb_src_t                            winner;

  logic [STARVE_WIDTH-1:0] starve_q, starve_d;
  logic                    write_enable_q, write_enable_d;
  logic [SELECT_WIDTH-1:0] write_select_q, write_select_d;
  logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;

  writeback_fifo #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SELECT_WIDTH(SELECT_WIDTH),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_alu_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (i_alu_valid),
    .i_push_select (i_alu_select),
    .i_push_data   (i_alu_data),
    .o_ready       (o_alu_ready),
    .i_pop         (winner == SRC_ALU),
    .o_head_select (alu_head_select),
    .o_head_data   (alu_head_data),
    .o_count       (alu_count),
    .o_entry_valid (alu_entry_valid),
    .o_entry_select(alu_entry_select)
  );

  writeback_fifo #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SELECT_WIDTH(SELECT_WIDTH),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_mem_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (i_mem_valid),
    .i_push_select (i_mem_select),
    .i_push_data   (i_mem_data),
    .o_ready       (o_mem_ready),
    .i_pop         (winner == SRC_MEM),
    .o_head_select (mem_head_select),
    .o_head_data   (mem_head_data),
    .o_count       (mem_count),
    .o_entry_valid (mem_entry_valid),
    .o_entry_select(mem_entry_select)
  );

  assign alu_nonempty = (alu_count != '0);
  assign mem_nonempty = (mem_count != '0);

  always_comb begin
    winner = SRC_NONE;
    if (alu_nonempty && mem_nonempty) begin
      winner = (starve_q == STARVE_WIDTH'(STARVE_LIMIT)) ? SRC_ALU : SRC_MEM;
    end else if (alu_nonempty) begin
      winner = SRC_ALU;
    end else if (mem_nonempty) begin
      winner = SRC_MEM;
    end
  end

  always_comb begin
    head_select = '0;
    head_data   = '0;
    unique case (winner)
      SRC_ALU: begin
        head_select = alu_head_select;
        head_data   = alu_head_data;
      end
      SRC_MEM: begin
        head_select = mem_head_select;
        head_data   = mem_head_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = '0;
    if (alu_nonempty && (winner != SRC_ALU)) begin
      starve_d = (starve_q == STARVE_WIDTH'(STARVE_LIMIT)) ? starve_q
                                                           : starve_q + STARVE_WIDTH'(1);
    end
  end

  // Out-of-range destinations still drain from the queue but never strobe the bank.
  always_comb begin
    write_enable_d = 1'b0;
    write_select_d = write_select_q;
    write_data_d   = write_data_q;
    if (winner != SRC_NONE) begin
      write_enable_d = (32'(head_select) < NUM_REG);
      write_select_d = head_select;
      write_data_d   = head_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q       <= '0;
      write_enable_q <= 1'b0;
      write_select_q <= '0;
      write_data_q   <= '0;
    end else begin
      starve_q       <= starve_d;
      write_enable_q <= write_enable_d;
      write_select_q <= write_select_d;
      write_data_q   <= write_data_d;
    end
  end

  assign o_write_enable = write_enable_q;
  assign o_write_select = write_select_q;
  assign o_write_data   = write_data_q;

  always_comb begin
    logic [SELECT_WIDTH-1:0] sel;
    o_pending = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      sel = alu_entry_select[i*SELECT_WIDTH +: SELECT_WIDTH];
      if (alu_entry_valid[i] && (32'(sel) < NUM_REG)) o_pending[sel] = 1'b1;
      sel = mem_entry_select[i*SELECT_WIDTH +: SELECT_WIDTH];
      if (mem_entry_valid[i] && (32'(sel) < NUM_REG)) o_pending[sel] = 1'b1;
    end
    if (write_enable_q) o_pending[write_select_q] = 1'b1;
  end

endmodule
